// File: rtl/pwm_pkg.sv
// rtl/pwm_pkg.sv - shared types and constants for the PWM capture block
//
// Purpose: FSM state encoding and default counter width used by
// pwm_capture_if, pwm_edge_sync and pwm_capture.
// Ports: none (package).
package pwm_pkg;

  localparam int W_DEFAULT = 12;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HIGH    = 2'd1,
    LOW     = 2'd2,
    TIMEOUT = 2'd3
  } pwm_state_t;

endpackage

// File: rtl/pwm_capture_if.sv
// rtl/pwm_capture_if.sv - PWM input and measurement result bundle
//
// Purpose: groups the PWM pin and the measurement outputs of pwm_capture.
// Signals:
//   pwm_in      - raw PWM waveform, asynchronous to the capture clock
//   period      - clk cycles between the last two accepted rising edges
//   high_time   - clk cycles the input was high within that period
//   meas_valid  - one-cycle pulse, period/high_time updated in that cycle
//   stuck       - level, no edge seen for 2^W-1 cycles
//   stuck_level - synchronized input level captured when stuck asserted
// Modports: master = capture block, slave = waveform source / result consumer.
interface pwm_capture_if
  import pwm_pkg::*;
#(
  parameter int W = W_DEFAULT
);

  logic         pwm_in;
  logic [W-1:0] period;
  logic [W-1:0] high_time;
  logic         meas_valid;
  logic         stuck;
  logic         stuck_level;

  modport master (
    input  pwm_in,
    output period, high_time, meas_valid, stuck, stuck_level
  );

  modport slave (
    output pwm_in,
    input  period, high_time, meas_valid, stuck, stuck_level
  );

endinterface

// File: rtl/pwm_edge_sync.sv
// rtl/pwm_edge_sync.sv - PWM synchronizer, optional glitch filter, edge pulses
//
// Purpose: brings pwm_in into the clk domain and produces registered
// one-cycle rise/fall pulses plus the accepted (synchronized) level.
// Optional feature: PWM_CAPTURE_GLITCH_FILTER_EN - a level change is only
// accepted after two consecutive equal synchronized samples, which drops
// one-cycle pulses and adds one cycle of edge latency (4 instead of 3).
// Ports:
//   clk, reset_n - clock, asynchronous active-low reset
//   pin          - raw asynchronous input
//   level        - accepted synchronized level
//   rise, fall   - one-cycle pulses on accepted transitions
module pwm_edge_sync (
  input  logic clk,
  input  logic reset_n,
  input  logic pin,
  output logic level,
  output logic rise,
  output logic fall
);

  logic sync1;
  logic sync2;
  logic accept;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
  logic sync2_d;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync2_d <= 1'b0;
    end else begin
      sync2_d <= sync2;
    end
  end

  // New level must be seen on two consecutive samples before it counts.
  assign accept = (sync2 == sync2_d) && (sync2 != level);
`else
  assign accept = (sync2 != level);
`endif

  // Rise and fall are mutually exclusive because both derive from one accept.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      level <= 1'b0;
      rise  <= 1'b0;
      fall  <= 1'b0;
    end else begin
      rise <= accept & sync2;
      fall <= accept & ~sync2;
      if (accept) begin
        level <= sync2;
      end
    end
  end

endmodule

// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period / high-time measurement with stuck detection
//
// Purpose: measures period and high time of pwm_in in clk cycles, rise to
// rise. The first partial period after reset or a timeout is discarded.
// Optional feature: PWM_CAPTURE_GLITCH_FILTER_EN (see pwm_edge_sync).
// Ports:
//   clk     - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   bus     - pwm_capture_if.master: pwm_in in, measurement results out
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int W = W_DEFAULT
) (
  input  logic               clk,
  input  logic               reset_n,
  pwm_capture_if.master      bus
);

  localparam logic [W-1:0] CNT_ONE  = {{(W-1){1'b0}}, 1'b1};
  localparam logic [W-1:0] CNT_MAX  = {W{1'b1}};
  // One below saturation: reaching it with no edge is the timeout, so a
  // period of 2^W-1 can never be reported.
  localparam logic [W-1:0] CNT_LAST = {{(W-1){1'b1}}, 1'b0};

  logic level;
  logic rise;
  logic fall;

  pwm_state_t   state;
  logic [W-1:0] cnt;
  logic [W-1:0] hcnt;
  logic [W-1:0] period_q;
  logic [W-1:0] high_q;
  logic         meas_valid_q;
  logic         stuck_q;
  logic         stuck_level_q;

  pwm_edge_sync u_edge_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .pin     (bus.pwm_in),
    .level   (level),
    .rise    (rise),
    .fall    (fall)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state         <= IDLE;
      cnt           <= '0;
      hcnt          <= '0;
      period_q      <= '0;
      high_q        <= '0;
      meas_valid_q  <= 1'b0;
      stuck_q       <= 1'b0;
      stuck_level_q <= 1'b0;
    end else begin
      meas_valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (rise) begin
            cnt   <= CNT_ONE;
            state <= HIGH;
          end
        end

        HIGH: begin
          // At the limit the period is already too long to report, so the
          // timeout wins even over a coincident fall.
          if (cnt == CNT_LAST) begin
            cnt           <= CNT_MAX;
            stuck_q       <= 1'b1;
            stuck_level_q <= level;
            state         <= TIMEOUT;
          end else if (fall) begin
            hcnt  <= cnt;
            cnt   <= cnt + CNT_ONE;
            state <= LOW;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        LOW: begin
          // A rise at the limit still yields the largest legal period.
          if (rise) begin
            period_q     <= cnt;
            high_q       <= hcnt;
            meas_valid_q <= 1'b1;
            cnt          <= CNT_ONE;
            state        <= HIGH;
          end else if (cnt == CNT_LAST) begin
            cnt           <= CNT_MAX;
            stuck_q       <= 1'b1;
            stuck_level_q <= level;
            state         <= TIMEOUT;
          end else begin
            cnt <= cnt + CNT_ONE;
          end
        end

        TIMEOUT: begin
          if (rise) begin
            stuck_q <= 1'b0;
            cnt     <= CNT_ONE;
            state   <= HIGH;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.period      = period_q;
  assign bus.high_time   = high_q;
  assign bus.meas_valid  = meas_valid_q;
  assign bus.stuck       = stuck_q;
  assign bus.stuck_level = stuck_level_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - self-checking bench for pwm_capture
module tb_pwm_capture;

  localparam int W = 12;

  logic clk = 1'b0;
  logic reset_n = 1'b0;

  pwm_capture_if #(.W(W)) bus ();

  pwm_capture #(.W(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  typedef struct {
    int high;
    int low;
    int reps;
    int exp_period;
    int exp_high;
  } vec_t;

  typedef struct {
    int p;
    int h;
  } meas_t;

  meas_t exp_q[$];
  meas_t prev;
  meas_t mon_m;
  meas_t last_seen;
  bit    armed = 1'b0;
  int    errors = 0;
  int    checks = 0;
  vec_t  vecs[6];

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, req);
    end
  endtask

  task automatic pin(input logic lvl, input int n);
    bus.pwm_in = lvl;
    repeat (n) @(negedge clk);
  endtask

  // A rise closes the previous period; its measurement is expected only if
  // an earlier rise was already accepted.
  task automatic do_rise(input int p, input int h);
    if (armed) exp_q.push_back(prev);
    prev.p = p;
    prev.h = h;
    armed = 1'b1;
    bus.pwm_in = 1'b1;
  endtask

  task automatic period_drive(input int h, input int l, input int p, input int eh);
    do_rise(p, eh);
    pin(1'b1, h);
    pin(1'b0, l);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_period"}, int'(bus.period), 0);
    chk({tag, "_high_time"}, int'(bus.high_time), 0);
    chk({tag, "_meas_valid"}, int'(bus.meas_valid), 0);
    chk({tag, "_stuck"}, int'(bus.stuck), 0);
    chk({tag, "_stuck_level"}, int'(bus.stuck_level), 0);
  endtask

  always @(negedge clk) begin
    if (reset_n && bus.meas_valid) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_meas_valid period=%0d high_time=%0d required=no pulse",
                 bus.period, bus.high_time);
      end else begin
        mon_m = exp_q.pop_front();
        chk("period", int'(bus.period), mon_m.p);
        chk("high_time", int'(bus.high_time), mon_m.h);
        last_seen = mon_m;
      end
    end
  end

  initial begin
    vecs[0] = '{64, 192, 4, 256, 64};
    vecs[1] = '{128, 128, 3, 256, 128};
    vecs[2] = '{192, 64, 3, 256, 192};
    vecs[3] = '{3, 7, 3, 10, 3};
    vecs[4] = '{2000, 2094, 2, 4094, 2000};
    vecs[5] = '{100, 50, 2, 150, 100};

    bus.pwm_in = 1'b0;
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    chk_all_zero("reset");
    reset_n = 1'b1;
    pin(1'b0, 5);

    for (int v = 0; v < 6; v++) begin
      for (int r = 0; r < vecs[v].reps; r++) begin
        period_drive(vecs[v].high, vecs[v].low, vecs[v].exp_period, vecs[v].exp_high);
      end
    end

    // 100/100 waveform with a one-cycle high glitch in the low phase
`ifdef PWM_CAPTURE_GLITCH_FILTER_EN
    do_rise(200, 100);
    pin(1'b1, 100);
    pin(1'b0, 40);
    pin(1'b1, 1);
    pin(1'b0, 59);
`else
    do_rise(140, 100);
    pin(1'b1, 100);
    pin(1'b0, 40);
    do_rise(60, 1);
    pin(1'b1, 1);
    pin(1'b0, 59);
`endif
    period_drive(100, 100, 200, 100);

    // Reset in the middle of a high phase
    do_rise(0, 0);
    pin(1'b1, 20);
    chk("queue_before_reset", exp_q.size(), 0);
    reset_n = 1'b0;
    #1;
    chk_all_zero("mid_reset");
    @(negedge clk);
    bus.pwm_in = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    armed = 1'b0;
    pin(1'b0, 50);
    period_drive(30, 70, 100, 30);
    chk("period_held_after_first_rise", int'(bus.period), 0);
    period_drive(20, 60, 80, 20);

    // Input held low long enough to time out
    do_rise(0, 0);
    pin(1'b1, 10);
    pin(1'b0, 4080);
    chk("stuck_before_limit", int'(bus.stuck), 0);
    pin(1'b0, 15);
    chk("stuck_after_limit", int'(bus.stuck), 1);
    chk("stuck_level", int'(bus.stuck_level), 0);
    chk("period_held_in_stuck", int'(bus.period), last_seen.p);
    chk("high_time_held_in_stuck", int'(bus.high_time), last_seen.h);
    armed = 1'b0;
    pin(1'b0, 905);
    do_rise(40, 10);
    pin(1'b1, 6);
    chk("stuck_cleared", int'(bus.stuck), 0);
    pin(1'b1, 4);
    pin(1'b0, 30);
    period_drive(10, 30, 40, 10);
    do_rise(0, 0);
    pin(1'b1, 10);
    pin(1'b0, 20);
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
PWM_CAPTURE -- requirements
Module: pwm_capture

Interface
REQ-001 Parameter: W, default 12, width of the period/high-time counters and of the measurement outputs.
REQ-002 clk  input  1  single system clock; all state updates on the rising edge.
REQ-003 reset_n  input  1  reset, asynchronous assert, active-low.
REQ-004 pwm_in  input  1  PWM waveform, asynchronous to clk.
REQ-005 period  output  W  clk cycles between the last two accepted rising edges of pwm_in.
REQ-006 high_time  output  W  clk cycles pwm_in was high within that period.
REQ-007 meas_valid  output  1  one-cycle pulse; period/high_time updated in the same cycle.
REQ-008 stuck  output  1  level; no edge seen for 2^W-1 cycles.
REQ-009 stuck_level  output  1  synchronized pwm_in level captured when stuck asserted.

Function
REQ-010 pwm_in SHALL pass through a 2-flop synchronizer, then an edge detector; a pin edge is detected 3 clk cycles after it, a constant offset that SHALL NOT affect measured counts.
REQ-011 FSM states SHALL be IDLE, HIGH, LOW, TIMEOUT.
REQ-012 IDLE: wait for a detected rise, ignoring any partial first period; on rise -> HIGH, cnt := 1, no meas_valid.
REQ-013 HIGH: cnt increments each cycle; on detected fall, hcnt := cnt, -> LOW.
REQ-014 LOW: cnt increments; on detected rise, period := cnt, high_time := hcnt, meas_valid := 1 for one cycle, cnt := 1, -> HIGH.
REQ-015 If cnt reaches 2^W-1 in HIGH or LOW with no edge, the FSM SHALL -> TIMEOUT, set stuck := 1 and stuck_level := synchronized level, and hold period/high_time unchanged.
REQ-016 TIMEOUT: cnt holds; on detected rise, stuck := 0, cnt := 1, -> HIGH, no meas_valid for that partial period.
REQ-017 The counter SHALL saturate and never wrap; period = 2^W-1 is never reported (it is a timeout).
REQ-018 A rise and fall cannot occur in the same cycle after edge detection; a one-cycle high pulse SHALL yield high_time = 1.
REQ-019 period and high_time SHALL hold their last values between meas_valid pulses; high_time < period always.

Reset
REQ-020 reset_n low SHALL asynchronously force state IDLE, synchronizer/edge flops 0, cnt/hcnt 0, period 0, high_time 0, meas_valid 0, stuck 0, stuck_level 0.
REQ-021 Reset mid-period SHALL discard the partial measurement; the first meas_valid after release requires two detected rises.

Configuration
REQ-022 Macro PWM_CAPTURE_GLITCH_FILTER_EN defined: a synchronized level change is accepted only after 2 consecutive equal samples; pulses of 1 clk on pwm_in are ignored; edge latency becomes 4 cycles.
REQ-023 Macro undefined: no filter; every synchronized transition is an edge; latency 3 cycles.

Structure
REQ-024 Package pwm_pkg SHALL hold the FSM state typedef (IDLE/HIGH/LOW/TIMEOUT) and the default W constant.
REQ-025 Sub-module pwm_edge_sync SHALL contain the synchronizer, optional glitch filter and rise/fall pulse outputs; pwm_capture holds the FSM and counters.

Verification
REQ-026 Drive pwm_basic (n=8), duty=64 -> from the second rise, meas_valid every 256 cycles with period=256, high_time=64.
REQ-027 Change duty 64->128->192 on the fly -> after one transition period, high_time=128 then 192, period stays 256.
REQ-028 Hold pwm_in low 5000 cycles (W=12) -> stuck=1 at 4095 cycles after the last edge, stuck_level=0, no meas_valid; then 10 high/30 low -> stuck clears on rise, first meas_valid period=40, high_time=10.
REQ-029 Assert reset_n mid-HIGH for 3 cycles -> all outputs 0 immediately; first meas_valid only after two subsequent rises.
REQ-030 1-cycle high glitches in a 100/100 waveform -> with PWM_CAPTURE_GLITCH_FILTER_EN: period=200, high_time=100; without it: a glitch is measured as high_time=1.
